xor_checker: RTL and testbench

//  Downstream self-check stage for the registered XOR stage (x1, x2 -> f).

---
 rtl/xor_checker_if.sv | 40 ++++
 rtl/xor_checker.sv | 181 ++++++++++++++++++
 tb/tb_xor_checker.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_checker_if.sv
// ----------------------------------------------------------------------------
// xor_checker_if : signal bundle between a stimulus/XOR-stage owner (master)
// and the xor_checker self-check block (slave).
// Optional macro XOR_CHK_FIRST_ERR_EN adds first_err_idx / first_err_f.
// ----------------------------------------------------------------------------
interface xor_checker_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic             clear;
   logic             x1;
   logic             x2;
   logic             f;
   logic             busy;
   logic             error;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] err_cnt;
`ifdef XOR_CHK_FIRST_ERR_EN
   logic [CNT_W-1:0] first_err_idx;
   logic             first_err_f;
`endif

   // Stimulus side: drives controls, the XOR operands and the stage output
   modport master (
      output enable, clear, x1, x2, f,
      input  busy, error, sample_cnt, err_cnt
`ifdef XOR_CHK_FIRST_ERR_EN
      , input first_err_idx, first_err_f
`endif
   );

   // Checker side
   modport slave (
      input  enable, clear, x1, x2, f,
      output busy, error, sample_cnt, err_cnt
`ifdef XOR_CHK_FIRST_ERR_EN
      , output first_err_idx, first_err_f
`endif
   );
endinterface

// File: rtl/xor_checker.sv
// ----------------------------------------------------------------------------
// xor_checker : self-check stage for a registered XOR (x1, x2 -> f).
// x1^x2 is pushed through a LATENCY-deep delay line together with a valid
// bit; the tap at stage LATENCY-1 is compared against the live f. Saturating
// sample / mismatch counters and a sticky error flag report the result.
// A small FSM only produces busy; it never gates a compare.
// Optional macro XOR_CHK_FIRST_ERR_EN adds the first-mismatch capture ports.
// ----------------------------------------------------------------------------
module xor_checker #(
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic         clock,
   input  logic         reset_n,
   xor_checker_if.slave bus
);

   // Elaboration guard: the delay line and 3-bit fill counter only cover 1..8
   generate
      if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
         $error("xor_checker: LATENCY must be in 1..8");
      end
   endgenerate

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [2:0]       FCNT_LAST = 3'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [LATENCY-1:0] r_exp;
   logic [LATENCY-1:0] r_vld;
   logic               w_xor;
   logic               w_exp_tap;
   logic               w_vld_tap;
   logic               w_mismatch;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [2:0]         r_fcnt;
   logic [2:0]         w_fcnt_next;

   logic [CNT_W-1:0]   r_sample_cnt;
   logic [CNT_W-1:0]   r_err_cnt;
   logic               r_error;

   assign w_xor      = bus.x1 ^ bus.x2;
   assign w_exp_tap  = r_exp[LATENCY-1];
   assign w_vld_tap  = r_vld[LATENCY-1];
   // Only a valid tap can produce a mismatch; gaps in enable never count
   assign w_mismatch = w_vld_tap && (bus.f != w_exp_tap);

   // Delay line: expected value and valid flag advance one stage per clock
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_exp <= '0;
         r_vld <= '0;
      end else if (bus.clear) begin
         r_exp <= '0;
         r_vld <= '0;
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            r_exp[i] <= r_exp[i-1];
            r_vld[i] <= r_vld[i-1];
         end
         r_exp[0] <= w_xor;
         r_vld[0] <= bus.enable;
      end
   end

   // Saturating counters and sticky error, updated on every valid tap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_error      <= 1'b0;
      end else if (bus.clear) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_error      <= 1'b0;
      end else if (w_vld_tap) begin
         if (r_sample_cnt != CNT_MAX) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         end
         if (w_mismatch) begin
            if (r_err_cnt != CNT_MAX) begin
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            r_error <= 1'b1;
         end
      end
   end

`ifdef XOR_CHK_FIRST_ERR_EN
   logic [CNT_W-1:0] r_first_err_idx;
   logic             r_first_err_f;

   // Capture the 0-based sample index and f on the compare that sets error
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_first_err_idx <= '0;
         r_first_err_f   <= 1'b0;
      end else if (bus.clear) begin
         r_first_err_idx <= '0;
         r_first_err_f   <= 1'b0;
      end else if (w_mismatch && !r_error) begin
         r_first_err_idx <= r_sample_cnt;
         r_first_err_f   <= bus.f;
      end
   end

   assign bus.first_err_idx = r_first_err_idx;
   assign bus.first_err_f   = r_first_err_f;
`endif

   // Next-state logic: tracks fill / steady / drain of the delay line
   always_comb begin
      w_state_next = r_state;
      w_fcnt_next  = r_fcnt;
      case (r_state)
         S_IDLE: begin
            if (bus.enable) begin
               w_state_next = S_FILL;
               w_fcnt_next  = 3'd0;
            end
         end
         S_FILL: begin
            if (!bus.enable) begin
               w_state_next = S_DRAIN;
               w_fcnt_next  = 3'd0;
            end else if (r_fcnt == FCNT_LAST) begin
               w_state_next = S_CHECK;
            end else begin
               w_fcnt_next  = r_fcnt + 3'd1;
            end
         end
         S_CHECK: begin
            if (!bus.enable) begin
               w_state_next = S_DRAIN;
               w_fcnt_next  = 3'd0;
            end
         end
         S_DRAIN: begin
            if (bus.enable) begin
               w_state_next = S_FILL;
               w_fcnt_next  = 3'd0;
            end else if (r_fcnt == FCNT_LAST) begin
               w_state_next = S_IDLE;
            end else begin
               w_fcnt_next  = r_fcnt + 3'd1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_fcnt_next  = 3'd0;
         end
      endcase
   end

   // State register; clear returns to IDLE like reset does
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_fcnt  <= 3'd0;
      end else if (bus.clear) begin
         r_state <= S_IDLE;
         r_fcnt  <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_fcnt  <= w_fcnt_next;
      end
   end

   assign bus.busy       = (r_state != S_IDLE);
   assign bus.error      = r_error;
   assign bus.sample_cnt = r_sample_cnt;
   assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_xor_checker.sv
// ----------------------------------------------------------------------------
// tb_xor_checker : two checkers (LATENCY=1/CNT_W=16 and LATENCY=3/CNT_W=4)
// share enable/clear/x1/x2; each gets its own f from an ideal XOR stage of
// matching latency, optionally corrupted. A per-edge history of samples and
// the index of the last clear/reset give the expected compares.
// Honours XOR_CHK_FIRST_ERR_EN for the first-mismatch ports.
// ----------------------------------------------------------------------------
module tb_xor_checker;
   localparam int LAT_A = 1;
   localparam int CW_A  = 16;
   localparam int LAT_B = 3;
   localparam int CW_B  = 4;
   localparam int HMAX  = 8192;
   localparam int M_IDLE = 0, M_FILL = 1, M_CHECK = 2, M_DRAIN = 3;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   xor_checker_if #(.CNT_W(CW_A)) if_a ();
   xor_checker_if #(.CNT_W(CW_B)) if_b ();

   xor_checker #(.LATENCY(LAT_A), .CNT_W(CW_A)) u_dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (if_a)
   );
   xor_checker #(.LATENCY(LAT_B), .CNT_W(CW_B)) u_dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (if_b)
   );

   int     n_cmp = 0;
   int     n_bad = 0;
   int     ek    = 0;
   int     last_clr = -1;
   bit     en_h [HMAX];
   bit     x_h  [HMAX];
   int     lat  [2] = '{LAT_A, LAT_B};
   longint maxv [2] = '{(64'd1 << CW_A) - 1, (64'd1 << CW_B) - 1};

   longint m_cnt  [2];
   longint m_ecnt [2];
   bit     m_error[2];
   int     m_state[2];
   int     m_fcnt [2];
   longint m_fidx [2];
   bit     m_ff   [2];

   bit d_en, d_clr, d_x;
   bit d_f [2];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic zero_model(input int k);
      last_clr = k;
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_ecnt[i] = 0; m_error[i] = 0;
         m_state[i] = M_IDLE; m_fcnt[i] = 0;
         m_fidx[i] = 0; m_ff[i] = 0;
      end
   endtask

   task automatic check_all();
      chk("a.busy",  longint'(if_a.busy),       longint'(m_state[0] != M_IDLE));
      chk("a.error", longint'(if_a.error),      longint'(m_error[0]));
      chk("a.cnt",   longint'(if_a.sample_cnt), m_cnt[0]);
      chk("a.ecnt",  longint'(if_a.err_cnt),    m_ecnt[0]);
      chk("b.busy",  longint'(if_b.busy),       longint'(m_state[1] != M_IDLE));
      chk("b.error", longint'(if_b.error),      longint'(m_error[1]));
      chk("b.cnt",   longint'(if_b.sample_cnt), m_cnt[1]);
      chk("b.ecnt",  longint'(if_b.err_cnt),    m_ecnt[1]);
`ifdef XOR_CHK_FIRST_ERR_EN
      chk("a.fidx",  longint'(if_a.first_err_idx), m_fidx[0]);
      chk("a.ff",    longint'(if_a.first_err_f),   longint'(m_ff[0]));
      chk("b.fidx",  longint'(if_b.first_err_idx), m_fidx[1]);
      chk("b.ff",    longint'(if_b.first_err_f),   longint'(m_ff[1]));
`endif
   endtask

   // busy-state rules: fill for LATENCY cycles, drain for LATENCY cycles
   task automatic fsm_step(input int i);
      case (m_state[i])
         M_IDLE:  if (d_en) begin m_state[i] = M_FILL; m_fcnt[i] = 0; end
         M_FILL:  if (!d_en) begin m_state[i] = M_DRAIN; m_fcnt[i] = 0; end
                  else if (m_fcnt[i] == lat[i] - 1) m_state[i] = M_CHECK;
                  else m_fcnt[i]++;
         M_CHECK: if (!d_en) begin m_state[i] = M_DRAIN; m_fcnt[i] = 0; end
         default: if (d_en) begin m_state[i] = M_FILL; m_fcnt[i] = 0; end
                  else if (m_fcnt[i] == lat[i] - 1) m_state[i] = M_IDLE;
                  else m_fcnt[i]++;
      endcase
   endtask

   // Expected effect of one rising edge, using the inputs held across it
   task automatic model_edge();
      int k;
      k = ek;
      if (!reset_n || d_clr) begin
         zero_model(k);
      end else begin
         for (int i = 0; i < 2; i++) begin
            int j;
            j = k - lat[i];
            if (j > last_clr && en_h[j]) begin
               if (d_f[i] != x_h[j]) begin
                  if (!m_error[i]) begin
                     m_fidx[i] = m_cnt[i];
                     m_ff[i]   = d_f[i];
                  end
                  if (m_ecnt[i] < maxv[i]) m_ecnt[i]++;
                  m_error[i] = 1'b1;
               end
               if (m_cnt[i] < maxv[i]) m_cnt[i]++;
            end
            fsm_step(i);
         end
      end
      en_h[k] = d_en;
      x_h[k]  = d_x;
   endtask

   // Drive inputs for the next edge; f comes from an ideal stage, ^bad
   task automatic drive(input bit en, input bit clr, input bit a1, input bit a2,
                        input bit ba, input bit bb);
      int j;
      d_en = en; d_clr = clr; d_x = a1 ^ a2;
      j = ek - LAT_A;
      d_f[0] = ((j >= 0) ? x_h[j] : 1'b0) ^ ba;
      j = ek - LAT_B;
      d_f[1] = ((j >= 0) ? x_h[j] : 1'b0) ^ bb;
      if_a.enable = en;  if_b.enable = en;
      if_a.clear  = clr; if_b.clear  = clr;
      if_a.x1     = a1;  if_b.x1     = a1;
      if_a.x2     = a2;  if_b.x2     = a2;
      if_a.f      = d_f[0];
      if_b.f      = d_f[1];
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      if (ek < HMAX - 1) ek++;
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse between edges; outputs must drop at once
   task automatic pulse_reset();
      #3;
      reset_n = 1'b0;
      #1;
      zero_model(ek - 1);
      check_all();
      chk("rst.a.busy", longint'(if_a.busy), 0);
      chk("rst.b.cnt",  longint'(if_b.sample_cnt), 0);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n, input bit ba, input bit bb);
      for (int c = 0; c < n; c++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, ba, bb);
         step();
      end
   endtask

   task automatic do_clear();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      zero_model(-1);
      // Reset held over three edges
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) step();
      #2 reset_n = 1'b1;
      $display("phase reset: compared=%0d", n_cmp);

      // 1: fixed 00,01,10,11 pattern, correct f, 16 enabled cycles
      for (int n = 0; n < 16; n++) begin
         drive(1'b1, 1'b0, 1'((n >> 1) & 1), 1'(n & 1), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("t1.a.busy_hold", longint'(if_a.busy), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("t1.a.busy_fall", longint'(if_a.busy), 0);
      idle_cycles(4, 1'b0, 1'b0);
      chk("t1.a.cnt", longint'(if_a.sample_cnt), 16);
      chk("t1.a.ecnt", longint'(if_a.err_cnt), 0);
      chk("t1.b.cnt_sat", longint'(if_b.sample_cnt), 15);
      $display("phase t1 pattern: compared=%0d", n_cmp);

      // 2: same pattern, f wrong on the 3rd sample (x1x2=10)
      do_clear();
      for (int n = 0; n < 16; n++) begin
         drive(1'b1, 1'b0, 1'((n >> 1) & 1), 1'(n & 1),
               1'(n - LAT_A == 2), 1'(n - LAT_B == 2));
         step();
      end
      idle_cycles(6, 1'b0, 1'b0);
      chk("t2.a.ecnt", longint'(if_a.err_cnt), 1);
      chk("t2.a.error", longint'(if_a.error), 1);
      chk("t2.b.ecnt", longint'(if_b.err_cnt), 1);
`ifdef XOR_CHK_FIRST_ERR_EN
      chk("t2.a.fidx", longint'(if_a.first_err_idx), 2);
      chk("t2.a.ff", longint'(if_a.first_err_f), 0);
`endif
      $display("phase t2 single error: compared=%0d", n_cmp);

      // 3: enable toggling every cycle for 8 cycles
      do_clear();
      for (int n = 0; n < 8; n++) begin
         drive(1'(n % 2 == 0), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         step();
      end
      idle_cycles(6, 1'b0, 1'b0);
      chk("t3.a.cnt", longint'(if_a.sample_cnt), 4);
      chk("t3.b.cnt", longint'(if_b.sample_cnt), 4);
      $display("phase t3 gaps: compared=%0d", n_cmp);

      // 4: f inverted on every sample, counters saturate on the narrow unit
      do_clear();
      for (int n = 0; n < 22; n++) begin
         drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         step();
      end
      idle_cycles(6, 1'b1, 1'b1);
      chk("t4.b.cnt", longint'(if_b.sample_cnt), 15);
      chk("t4.b.ecnt", longint'(if_b.err_cnt), 15);
      chk("t4.a.cnt", longint'(if_a.sample_cnt), 22);
      chk("t4.a.ecnt", longint'(if_a.err_cnt), 22);
      $display("phase t4 saturation: compared=%0d", n_cmp);

      // 5: async reset mid-CHECK, then clear colliding with enable+mismatch
      do_clear();
      for (int n = 0; n < 6; n++) begin
         drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         if (n == 4) pulse_reset();
         step();
      end
      for (int n = 0; n < 4; n++) begin
         drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         step();
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      chk("t5.a.cnt", longint'(if_a.sample_cnt), 0);
      chk("t5.a.error", longint'(if_a.error), 0);
      chk("t5.b.ecnt", longint'(if_b.err_cnt), 0);
      idle_cycles(6, 1'b0, 1'b0);
      $display("phase t5 reset/clear: compared=%0d", n_cmp);

      // 6: one-cycle enable gap in CHECK, no lost or duplicated compares
      do_clear();
      for (int n = 0; n < 13; n++) begin
         drive(1'(n != 6), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         step();
      end
      idle_cycles(6, 1'b0, 1'b0);
      chk("t6.a.cnt", longint'(if_a.sample_cnt), 12);
      chk("t6.b.cnt", longint'(if_b.sample_cnt), 12);
      $display("phase t6 gap in check: compared=%0d", n_cmp);

      // Random traffic with sporadic errors, clears and reset pulses
      p0 = n_cmp;
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 99) == 0) pulse_reset();
         step();
      end
      idle_cycles(6, 1'b0, 1'b0);
      $display("phase random: compared=%0d", n_cmp - p0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
